caliptra_apb_initiator: RTL and testbench
=========================================

// Module: caliptra_apb_initiator
// PURPOSE
//  APB3 requester that drives the Caliptra SoC-side APB slave (PADDR/PSEL/PENABLE/PWRITE/PWDATA/PAUSER/PPROT).
//  Accepts one command at a time from a valid/ready request channel and runs the SETUP/ACCESS sequence.
//  Returns read data or error on a valid/ready response channel; a watchdog aborts transfers on hung PREADY.
//  Sits in the FPGA wrapper between the host-facing register/AXI side and caliptra_top's APB port.
// PARAMETERS
//  ADDR_W          32    APB address width; equals CALIPTRA_APB_ADDR_WIDTH
//  DATA_W          32    APB data width; equals CALIPTRA_APB_DATA_WIDTH
//  USER_W          32    PAUSER width; equals CALIPTRA_APB_USER_WIDTH
//  TIMEOUT_CYCLES  1024  max ACCESS cycles waiting for PREADY; 0 disables the watchdog
// PORTS
//  core_clk     in   1       single clock for all logic
//  core_rst     in   1       asynchronous, active-high reset
//  cmd_valid    in   1       command present
//  cmd_ready    out  1       command accepted when cmd_valid && cmd_ready
//  cmd_write    in   1       1 = write, 0 = read
//  cmd_addr     in   ADDR_W  target address
//  cmd_wdata    in   DATA_W  write data (ignored on reads)
//  cmd_user     in   USER_W  driven on PAUSER for the transfer
//  cmd_prot     in   3       driven on PPROT for the transfer
//  rsp_valid    out  1       response held until rsp_ready
//  rsp_ready    in   1       response consumed when rsp_valid && rsp_ready
//  rsp_rdata    out  DATA_W  PRDATA captured on reads; 0 on writes and on timeout
//  rsp_err      out  1       PSLVERR sampled at completion, or timeout
//  rsp_timeout  out  1       watchdog expired
//  busy         out  1       state != IDLE
//  PADDR PWRITE PWDATA PAUSER PPROT PSEL PENABLE  out  APB request, all registered
//  PRDATA in DATA_W, PREADY in 1, PSLVERR in 1    APB completion inputs
// BEHAVIOUR
//  - Reset: every output 0, state IDLE, watchdog counter 0; applies immediately, mid-transfer included.
//    Any in-flight transfer is dropped with no response; PSEL and PENABLE fall asynchronously.
//  - FSM: IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
//  - cmd_ready = (state==IDLE). Command fields are latched on acceptance.
//  - Accept in cycle N: N+1 SETUP, with PSEL=1, PENABLE=0, and address/data/ctrl/user/prot valid.
//    N+2 ACCESS, with PENABLE=1. APB request fields are held stable from SETUP to the end of ACCESS.
//  - ACCESS with PREADY=1: transfer completes.
//    Capture PRDATA (reads only) and PSLVERR; next cycle PSEL=PENABLE=0, state RESP, rsp_valid=1.
//    Minimum latency from accept to rsp_valid is 3 cycles.
//  - Watchdog: counts ACCESS cycles with PREADY=0.
//    On reaching TIMEOUT_CYCLES: drop PSEL/PENABLE and go to RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
//    PREADY=1 on the expiry cycle counts as completion (completion wins). Counter clears on entering SETUP.
//  - RESP: outputs are stable while rsp_valid && !rsp_ready.
//    On handshake: rsp_valid=0 and return to IDLE; cmd_ready=1 the following cycle. No back-to-back overlap.
//  - PSLVERR and PRDATA are ignored outside ACCESS. PREADY is ignored in SETUP.
//  - Counter width: $clog2(TIMEOUT_CYCLES+1); no wrap; saturates at expiry.
//  - Assertions: PENABLE implies PSEL; APB request fields are stable while PSEL && !(PENABLE && PREADY);
//    rsp_timeout implies rsp_err.
// STRUCTURE
//  - caliptra_apb_initiator_pkg holds:
//    typedef enum logic [1:0] apb_init_state_e {IDLE, SETUP, ACCESS, RESP};
//    typedef struct packed apb_init_rsp_t {rdata, err, timeout}.
//  - One sub-module: caliptra_apb_watchdog (load/enable/count/expired, parameterised by TIMEOUT_CYCLES).
//  - No memories; roughly 200 lines of RTL total.
// TESTING
//  1. Write addr=0x3002_0000, wdata=0xA5A5_5A5A, slave PREADY=1 immediately.
//     -> PSEL@N+1, PENABLE@N+2, rsp_valid@N+3, err=0, rdata=0.
//  2. Read, slave inserts 5 wait states, PRDATA=0xDEAD_BEEF. -> request fields stable 7 cycles, rsp_rdata=0xDEAD_BEEF.
//  3. Read with PSLVERR=1 at completion. -> rsp_err=1, rsp_timeout=0; next command accepted after rsp handshake.
//  4. TIMEOUT_CYCLES=16, PREADY held 0. -> PSEL=0 after 16 ACCESS cycles, rsp_err=1, rsp_timeout=1, rdata=0.
//     Repeat with PREADY=1 on cycle 16 -> normal completion.
//  5. rsp_ready held 0 for 10 cycles. -> rsp_* stable, cmd_ready=0, cmd_valid ignored, PSEL stays 0.
//  6. Assert core_rst during ACCESS. -> PSEL/PENABLE/rsp_valid/busy 0 immediately.
//     After release: IDLE, cmd_ready=1, no stale response.

Source files
------------

// File: rtl/caliptra_apb_initiator_pkg.sv
// Shared types and widths for the Caliptra APB initiator.
package caliptra_apb_initiator_pkg;

    localparam int unsigned CALIPTRA_APB_ADDR_WIDTH = 32;
    localparam int unsigned CALIPTRA_APB_DATA_WIDTH = 32;
    localparam int unsigned CALIPTRA_APB_USER_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_init_state_e;

    // Response payload; rdata is sized for the widest supported DATA_W.
    typedef struct packed {
        logic [CALIPTRA_APB_DATA_WIDTH-1:0] rdata;
        logic                               err;
        logic                               timeout;
    } apb_init_rsp_t;

    // Watchdog counter width; a disabled watchdog still needs one bit.
    function automatic int unsigned wdog_cnt_w(input int unsigned timeout_cycles);
        return (timeout_cycles == 0) ? 1 : $clog2(timeout_cycles + 1);
    endfunction

endpackage

// File: rtl/caliptra_apb_initiator_if.sv
// Command/response channels plus the APB3 request/completion signals of the initiator.
interface caliptra_apb_initiator_if
    import caliptra_apb_initiator_pkg::*;
#(
    parameter int unsigned ADDR_W = CALIPTRA_APB_ADDR_WIDTH,
    parameter int unsigned DATA_W = CALIPTRA_APB_DATA_WIDTH,
    parameter int unsigned USER_W = CALIPTRA_APB_USER_WIDTH
);
    // Command channel
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [USER_W-1:0] cmd_user;
    logic [2:0]        cmd_prot;
    // Response channel
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;
    logic              busy;
    // APB request
    logic [ADDR_W-1:0] PADDR;
    logic              PWRITE;
    logic [DATA_W-1:0] PWDATA;
    logic [USER_W-1:0] PAUSER;
    logic [2:0]        PPROT;
    logic              PSEL;
    logic              PENABLE;
    // APB completion
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    // Initiator side
    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_user, cmd_prot, rsp_ready,
        input  PRDATA, PREADY, PSLVERR,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy,
        output PADDR, PWRITE, PWDATA, PAUSER, PPROT, PSEL, PENABLE
    );

    // Host and APB target side
    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_user, cmd_prot, rsp_ready,
        output PRDATA, PREADY, PSLVERR,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy,
        input  PADDR, PWRITE, PWDATA, PAUSER, PPROT, PSEL, PENABLE
    );

endinterface

// File: rtl/caliptra_apb_watchdog.sv
// Saturating ACCESS-phase wait counter; flags the cycle on which the limit is reached.
module caliptra_apb_watchdog
    import caliptra_apb_initiator_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,    // clear at the start of a transfer
    input  logic count_i,   // one stalled ACCESS cycle
    output logic expired_o  // this stalled cycle is the TIMEOUT_CYCLES-th one
);
    localparam int unsigned     CntW    = wdog_cnt_w(TIMEOUT_CYCLES);
    localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Clear on load, otherwise count stalled cycles up to the limit and hold there.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (count_i && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // Counter state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expiry is combinational so the initiator can abort in the same cycle.
    assign expired_o = (TIMEOUT_CYCLES != 0) && count_i && (cnt_q == CntLast);

endmodule

// File: rtl/caliptra_apb_initiator.sv
// APB3 requester for the Caliptra SoC APB port: one command at a time, registered APB
// request, response held until consumed, watchdog abort on a hung PREADY.
module caliptra_apb_initiator
    import caliptra_apb_initiator_pkg::*;
#(
    parameter int unsigned ADDR_W         = CALIPTRA_APB_ADDR_WIDTH,
    parameter int unsigned DATA_W         = CALIPTRA_APB_DATA_WIDTH,
    parameter int unsigned USER_W         = CALIPTRA_APB_USER_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input logic                    core_clk,
    input logic                    core_rst,
    caliptra_apb_initiator_if.master bus
);
    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_SETUP  = SETUP;
    localparam logic [1:0] ST_ACCESS = ACCESS;
    localparam logic [1:0] ST_RESP   = RESP;

    logic [1:0]        state_q, state_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic              pwrite_q, pwrite_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [USER_W-1:0] pauser_q, pauser_d;
    logic [2:0]        pprot_q, pprot_d;
    logic              rsp_valid_q, rsp_valid_d;
    apb_init_rsp_t     rsp_q, rsp_d;

    logic wd_load, wd_count, wd_expired;

    caliptra_apb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i     (core_clk),
        .rst_i     (core_rst),
        .load_i    (wd_load),
        .count_i   (wd_count),
        .expired_o (wd_expired)
    );

    // Transfer sequencing: latch on accept, SETUP, ACCESS until ready/timeout, hold response.
    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        pauser_d    = pauser_q;
        pprot_d     = pprot_q;
        rsp_valid_d = rsp_valid_q;
        rsp_d       = rsp_q;
        wd_load     = 1'b0;
        wd_count    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    paddr_d  = bus.cmd_addr;
                    pwrite_d = bus.cmd_write;
                    pwdata_d = bus.cmd_wdata;
                    pauser_d = bus.cmd_user;
                    pprot_d  = bus.cmd_prot;
                    psel_d   = 1'b1;
                    wd_load  = 1'b1;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                // Completion is checked first so PREADY on the expiry cycle still wins.
                if (bus.PREADY) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_d.rdata   = pwrite_q ? '0 : CALIPTRA_APB_DATA_WIDTH'(bus.PRDATA);
                    rsp_d.err     = bus.PSLVERR;
                    rsp_d.timeout = 1'b0;
                    state_d       = ST_RESP;
                end else begin
                    wd_count = 1'b1;
                    if (wd_expired) begin
                        psel_d        = 1'b0;
                        penable_d     = 1'b0;
                        rsp_valid_d   = 1'b1;
                        rsp_d.rdata   = '0;
                        rsp_d.err     = 1'b1;
                        rsp_d.timeout = 1'b1;
                        state_d       = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_d       = '0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // All state and APB request outputs; reset drops any in-flight transfer immediately.
    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            state_q     <= ST_IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            pauser_q    <= '0;
            pprot_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            pauser_q    <= pauser_d;
            pprot_q     <= pprot_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_q       <= rsp_d;
        end
    end

    // cmd_ready is gated by reset so every output reads 0 while reset is held.
    assign bus.cmd_ready   = (state_q == ST_IDLE) && !core_rst;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = DATA_W'(rsp_q.rdata);
    assign bus.rsp_err     = rsp_q.err;
    assign bus.rsp_timeout = rsp_q.timeout;
    assign bus.PADDR       = paddr_q;
    assign bus.PWRITE      = pwrite_q;
    assign bus.PWDATA      = pwdata_q;
    assign bus.PAUSER      = pauser_q;
    assign bus.PPROT       = pprot_q;
    assign bus.PSEL        = psel_q;
    assign bus.PENABLE     = penable_q;

    a_penable_psel: assert property (@(posedge core_clk) disable iff (core_rst)
        bus.PENABLE |-> bus.PSEL);

    a_req_stable: assert property (@(posedge core_clk) disable iff (core_rst)
        (bus.PSEL && !(bus.PENABLE && bus.PREADY)) |=>
        ($stable(bus.PADDR) && $stable(bus.PWRITE) && $stable(bus.PWDATA) &&
         $stable(bus.PAUSER) && $stable(bus.PPROT)));

    a_timeout_err: assert property (@(posedge core_clk) disable iff (core_rst)
        bus.rsp_timeout |-> bus.rsp_err);

endmodule

// File: tb/tb_caliptra_apb_initiator.sv
// Directed bench for caliptra_apb_initiator with a response scoreboard.
module tb_caliptra_apb_initiator;
    import caliptra_apb_initiator_pkg::*;

    localparam int unsigned TO = 16;

    logic core_clk = 1'b0;
    logic core_rst = 1'b1;
    always #5 core_clk = ~core_clk;

    caliptra_apb_initiator_if bus ();

    caliptra_apb_initiator #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .USER_W         (32),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .core_clk (core_clk),
        .core_rst (core_rst),
        .bus      (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    apb_init_rsp_t exp_q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic apb_init_rsp_t mk(input logic [31:0] d, input logic e, input logic t);
        apb_init_rsp_t r;
        r.rdata   = d;
        r.err     = e;
        r.timeout = t;
        return r;
    endfunction

    task automatic step();
        @(posedge core_clk);
        #1;
    endtask

    task automatic smp();
        @(negedge core_clk);
    endtask

    task automatic set_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] u, input logic [2:0] p);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        bus.cmd_user  = u;
        bus.cmd_prot  = p;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            smp();
            n++;
        end
        check(name, 128'(exp_q.size()), 128'd0);
    endtask

    // Response monitor: every handshake pops one expectation.
    initial begin : monitor
        apb_init_rsp_t e;
        forever begin
            @(negedge core_clk);
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got rsp rdata=0x%0h err=%0b timeout=%0b, required none",
                             bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_rdata", bus.rsp_rdata, e.rdata);
                    check("sb_err", bus.rsp_err, e.err);
                    check("sb_timeout", bus.rsp_timeout, e.timeout);
                end
            end
        end
    end

    initial begin : guard
        #100000;
        $display("FAIL tb_guard: got simulation time limit, required normal completion");
        $fatal(1, "bench time limit");
    end

    initial begin : stim
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.cmd_user  = '0;
        bus.cmd_prot  = '0;
        bus.rsp_ready = 1'b0;
        bus.PRDATA    = '0;
        bus.PREADY    = 1'b0;
        bus.PSLVERR   = 1'b0;

        // Reset state
        repeat (2) smp();
        check("rst_psel", bus.PSEL, 0);
        check("rst_penable", bus.PENABLE, 0);
        check("rst_paddr", bus.PADDR, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_cmd_ready", bus.cmd_ready, 0);
        check("rst_busy", bus.busy, 0);
        step();
        core_rst = 1'b0;
        smp();
        check("idle_cmd_ready", bus.cmd_ready, 1);

        // 1: write, zero wait states
        step();
        bus.PREADY = 1'b1;
        bus.rsp_ready = 1'b1;
        bus.PRDATA = 32'h1111_2222;
        set_cmd(1'b1, 32'h3002_0000, 32'hA5A5_5A5A, 32'h0000_00C1, 3'b010);
        exp_q.push_back(mk(32'h0, 1'b0, 1'b0));
        smp();
        check("t1_accept_ready", bus.cmd_ready, 1);
        step();
        bus.cmd_valid = 1'b0;
        smp();
        check("t1_setup_psel", bus.PSEL, 1);
        check("t1_setup_penable", bus.PENABLE, 0);
        check("t1_setup_fields", {bus.PADDR, bus.PWRITE, bus.PWDATA, bus.PAUSER, bus.PPROT},
              {32'h3002_0000, 1'b1, 32'hA5A5_5A5A, 32'h0000_00C1, 3'b010});
        check("t1_setup_busy", bus.busy, 1);
        check("t1_setup_ready", bus.cmd_ready, 0);
        smp();
        check("t1_access_psel", bus.PSEL, 1);
        check("t1_access_penable", bus.PENABLE, 1);
        check("t1_access_rsp_valid", bus.rsp_valid, 0);
        smp();
        check("t1_rsp_valid", bus.rsp_valid, 1);
        check("t1_rsp_psel", bus.PSEL, 0);
        check("t1_rsp_penable", bus.PENABLE, 0);
        smp();
        check("t1_idle_ready", bus.cmd_ready, 1);
        check("t1_idle_rsp_valid", bus.rsp_valid, 0);
        drain("t1_drain");

        // 2: read with 5 wait states
        step();
        bus.PREADY = 1'b0;
        set_cmd(1'b0, 32'h3002_0010, 32'h0, 32'h0000_00C2, 3'b001);
        exp_q.push_back(mk(32'hDEAD_BEEF, 1'b0, 1'b0));
        for (int i = 0; i < 7; i++) begin
            step();
            if (i == 0) bus.cmd_valid = 1'b0;
            if (i == 6) begin
                bus.PREADY = 1'b1;
                bus.PRDATA = 32'hDEAD_BEEF;
            end else begin
                bus.PRDATA = 32'h5555_0000 + 32'(i);
            end
            smp();
            check("t2_psel", bus.PSEL, 1);
            check("t2_penable", bus.PENABLE, 128'(i != 0));
            check("t2_fields", {bus.PADDR, bus.PWRITE, bus.PAUSER, bus.PPROT},
                  {32'h3002_0010, 1'b0, 32'h0000_00C2, 3'b001});
        end
        step();
        bus.PREADY = 1'b0;
        bus.PRDATA = 32'h0;
        smp();
        check("t2_rsp_valid", bus.rsp_valid, 1);
        check("t2_rsp_psel", bus.PSEL, 0);
        drain("t2_drain");

        // 3: read with PSLVERR, then next command after the handshake
        step();
        bus.PREADY = 1'b1;
        bus.PSLVERR = 1'b1;
        bus.PRDATA = 32'h1234_5678;
        set_cmd(1'b0, 32'h3002_0020, 32'h0, 32'h0000_00C3, 3'b000);
        exp_q.push_back(mk(32'h1234_5678, 1'b1, 1'b0));
        step();
        bus.cmd_valid = 1'b0;
        step();
        step();
        bus.PSLVERR = 1'b0;
        smp();
        check("t3_rsp_err", bus.rsp_err, 1);
        check("t3_rsp_timeout", bus.rsp_timeout, 0);
        check("t3_rsp_cmd_ready", bus.cmd_ready, 0);
        step();
        set_cmd(1'b1, 32'h3002_0024, 32'h0000_0001, 32'h0000_00C3, 3'b000);
        exp_q.push_back(mk(32'h0, 1'b0, 1'b0));
        smp();
        check("t3_next_ready", bus.cmd_ready, 1);
        step();
        bus.cmd_valid = 1'b0;
        smp();
        check("t3_next_setup", bus.PSEL, 1);
        drain("t3_drain");

        // 5: response back-pressure with a second command waiting
        step();
        bus.rsp_ready = 1'b0;
        bus.PREADY = 1'b1;
        set_cmd(1'b1, 32'h3002_0030, 32'hFEED_0001, 32'h0000_00C5, 3'b011);
        exp_q.push_back(mk(32'h0, 1'b0, 1'b0));
        step();
        set_cmd(1'b0, 32'h3002_0034, 32'h0, 32'h0000_00C6, 3'b100);
        step();
        for (int i = 0; i < 10; i++) begin
            step();
            smp();
            check("t5_rsp_valid", bus.rsp_valid, 1);
            check("t5_rsp_err", bus.rsp_err, 0);
            check("t5_rsp_rdata", bus.rsp_rdata, 0);
            check("t5_cmd_ready", bus.cmd_ready, 0);
            check("t5_psel", bus.PSEL, 0);
            check("t5_paddr_hold", bus.PADDR, 32'h3002_0030);
        end
        step();
        bus.rsp_ready = 1'b1;
        bus.PRDATA = 32'hCAFE_F00D;
        exp_q.push_back(mk(32'hCAFE_F00D, 1'b0, 1'b0));
        smp();
        check("t5_release_valid", bus.rsp_valid, 1);
        step();
        smp();
        check("t5_ready_after", bus.cmd_ready, 1);
        step();
        bus.cmd_valid = 1'b0;
        smp();
        check("t5_second_paddr", bus.PADDR, 32'h3002_0034);
        drain("t5_drain");

        // 4a: watchdog expiry
        step();
        bus.PREADY = 1'b0;
        bus.PRDATA = 32'hFFFF_FFFF;
        set_cmd(1'b0, 32'h3002_0040, 32'h0, 32'h0000_00C4, 3'b000);
        exp_q.push_back(mk(32'h0, 1'b1, 1'b1));
        step();
        bus.cmd_valid = 1'b0;
        for (int k = 1; k <= int'(TO); k++) begin
            step();
            smp();
            check("t4_wait_psel", bus.PSEL, 1);
        end
        step();
        smp();
        check("t4_to_psel", bus.PSEL, 0);
        check("t4_to_penable", bus.PENABLE, 0);
        check("t4_to_rsp_valid", bus.rsp_valid, 1);
        check("t4_to_timeout", bus.rsp_timeout, 1);
        check("t4_to_rdata", bus.rsp_rdata, 0);
        drain("t4a_drain");

        // 4b: PREADY on the expiry cycle completes normally
        step();
        set_cmd(1'b0, 32'h3002_0044, 32'h0, 32'h0000_00C4, 3'b000);
        exp_q.push_back(mk(32'h0BAD_F00D, 1'b0, 1'b0));
        step();
        bus.cmd_valid = 1'b0;
        for (int k = 1; k <= int'(TO); k++) begin
            step();
            if (k == int'(TO)) begin
                bus.PREADY = 1'b1;
                bus.PRDATA = 32'h0BAD_F00D;
            end
            smp();
            check("t4b_wait_psel", bus.PSEL, 1);
        end
        step();
        bus.PREADY = 1'b0;
        smp();
        check("t4b_rsp_valid", bus.rsp_valid, 1);
        check("t4b_rsp_timeout", bus.rsp_timeout, 0);
        drain("t4b_drain");

        // 6: reset during ACCESS
        step();
        set_cmd(1'b1, 32'h3002_0050, 32'h0000_1234, 32'h0000_00C7, 3'b001);
        step();
        bus.cmd_valid = 1'b0;
        step();
        smp();
        check("t6_in_access", bus.PENABLE, 1);
        #1;
        core_rst = 1'b1;
        #1;
        check("t6_rst_psel", bus.PSEL, 0);
        check("t6_rst_penable", bus.PENABLE, 0);
        check("t6_rst_rsp_valid", bus.rsp_valid, 0);
        check("t6_rst_busy", bus.busy, 0);
        step();
        step();
        core_rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            smp();
            check("t6_post_ready", bus.cmd_ready, 1);
            check("t6_post_busy", bus.busy, 0);
            check("t6_post_rsp_valid", bus.rsp_valid, 0);
            check("t6_post_psel", bus.PSEL, 0);
        end

        drain("final_drain");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
